// File: rtl/layer_pkg.sv
// -----------------------------------------------------------------------------
// layer_pkg
// Definitions shared by the layer engines (conv/max-pool, flatten) that sit on
// the common layer-memory bus.
//   - CSEL_* : memory-select codes driven on csel
//   - DATA_W : layer data width (signed Q4.16)
//   - ADDR_W : layer-memory address width
//   - L1_DEPTH : words per 32x32 L1 map
//   - flat_state_e : state encoding of the flatten sequencer
// -----------------------------------------------------------------------------
package layer_pkg;

  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 12;
  localparam int L1_DEPTH = 1024;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  typedef enum logic [2:0] {
    FL_IDLE = 3'd0,
    FL_RD   = 3'd1,
    FL_CAP  = 3'd2,
    FL_WR   = 3'd3,
    FL_FIN  = 3'd4
  } flat_state_e;

endpackage : layer_pkg

// File: rtl/flatten_l2.sv
// -----------------------------------------------------------------------------
// flatten_l2
// Layer-2 flatten stage. After the conv/max-pool engine has filled the two
// 32x32 L1 maps, one start pulse makes this block copy them into L2,
// interleaved element by element: L2[2*i+k] = L1K<k>[i].
// Each element takes three cycles: RD (present address), CAP (hold address,
// capture data), WR (write L2). The data word is passed through bit-exact.
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   start        one-cycle request, L1 complete (ignored while busy)
//   busy         high from the first RD through FIN
//   done         one-cycle pulse in FIN, L2 complete
//   crd          layer-memory read enable
//   caddr_rd     read address {2'b0, idx}
//   cdata_rd     read data (valid by the end of CAP)
//   cwr          layer-memory write enable
//   caddr_wr     write address {1'b0, idx, k}
//   cdata_wr     write data (captured read word)
//   csel         memory select (layer_pkg CSEL_* codes)
//   nz_count     nonzero words written in the last pass, held until next start
// -----------------------------------------------------------------------------
module flatten_l2
  import layer_pkg::*;
#(
  parameter int L1_DEPTH = layer_pkg::L1_DEPTH,
  parameter int DATA_W   = layer_pkg::DATA_W,
  parameter int ADDR_W   = layer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel,
  // 12 bits so that a fully nonzero pass (2048 words) is representable.
  output logic [11:0]       nz_count
);

  localparam int IDX_W = $clog2(L1_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(L1_DEPTH - 1);

  flat_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              k_q, k_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [11:0]       nz_q, nz_d;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FL_IDLE;
      idx_q   <= '0;
      k_q     <= 1'b0;
      data_q  <= '0;
      nz_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      data_q  <= data_d;
      nz_q    <= nz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    data_d  = data_q;
    nz_d    = nz_q;

    unique case (state_q)
      FL_IDLE: begin
        if (start) begin
          state_d = FL_RD;
          idx_d   = '0;
          k_d     = 1'b0;
          nz_d    = '0;
        end
      end

      FL_RD: state_d = FL_CAP;

      FL_CAP: begin
        data_d  = cdata_rd;
        state_d = FL_WR;
      end

      FL_WR: begin
        nz_d = nz_q + 12'(data_q != '0);
        if (!k_q) begin
          k_d     = 1'b1;
          state_d = FL_RD;
        end else if (idx_q == IDX_LAST) begin
          // Terminate by compare; idx never wraps.
          state_d = FL_FIN;
        end else begin
          k_d     = 1'b0;
          idx_d   = idx_q + 1'b1;
          state_d = FL_RD;
        end
      end

      FL_FIN: state_d = FL_IDLE;

      default: state_d = FL_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: registered state and counters only, so there is no
  // combinational path from any input to any output.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    caddr_rd = '0;
    cwr      = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    csel     = CSEL_NONE;

    unique case (state_q)
      FL_IDLE: ;

      // RD and CAP drive identical read signals so the address is stable for
      // the whole two-cycle read window.
      FL_RD, FL_CAP: begin
        busy     = 1'b1;
        crd      = 1'b1;
        caddr_rd = ADDR_W'(idx_q);
        csel     = k_q ? CSEL_L1K1 : CSEL_L1K0;
      end

      FL_WR: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        caddr_wr = ADDR_W'({idx_q, k_q});
        cdata_wr = data_q;
        csel     = CSEL_L2;
      end

      FL_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end

      default: ;
    endcase
  end

  assign nz_count = nz_q;

endmodule : flatten_l2

// File: tb/tb_flatten_l2.sv
// -----------------------------------------------------------------------------
// tb_flatten_l2
// Bench for flatten_l2 with L1/L2 memory models on the layer bus. A pass
// pushes its expected (cycle, address, data) writes into a queue built from
// the L1 contents; an independent monitor pops and compares on every write,
// checks the done pulse, and checks bus-protocol invariants every cycle.
// -----------------------------------------------------------------------------
module tb_flatten_l2;

  localparam int DW = 20;
  localparam int AW = 12;
  localparam int N  = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;
  logic [11:0]   nz_count;

  flatten_l2 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel),
    .nz_count (nz_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- memories
  logic [DW-1:0] l1k0 [N];
  logic [DW-1:0] l1k1 [N];
  logic [DW-1:0] l2   [2*N];
  logic [DW-1:0] rdata = '0;
  assign cdata_rd = rdata;

  always @(posedge clk) begin
    if (crd) begin
      if (csel == 3'b011)      rdata <= l1k0[caddr_rd[9:0]];
      else if (csel == 3'b100) rdata <= l1k1[caddr_rd[9:0]];
      else                     rdata <= 20'hDEAD5;
    end
    if (cwr && csel == 3'b101) l2[caddr_wr[10:0]] <= cdata_wr;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------- checking
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          rel;
    logic [11:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  wr_exp_t sb_q[$];
  int  e0_cyc    = 0;
  int  wr_cnt    = 0;
  int  exp_nz    = 0;
  bit  done_seen = 1'b0;
  bit  prev_crd  = 1'b0;
  bit  prev2_crd = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [2:0]    prev_csel = '0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int rel;
    rel = cyc - e0_cyc + 1;
    if (cwr && crd) check("rd_wr_overlap", 1, 0);
    if (crd) begin
      check("csel_on_read", 64'(csel == 3'b011 || csel == 3'b100), 1);
      if (prev_crd) begin
        check("rd_addr_stable", {caddr_rd, csel}, {prev_addr, prev_csel});
        if (prev2_crd) check("rd_window_len", 3, 2);
      end
    end
    if (cwr) begin
      check("csel_on_write", csel, 3'b101);
      if (sb_q.size() == 0) begin
        check("unexpected_write", caddr_wr, 12'hFFF);
      end else begin
        wr_exp_t e;
        e = sb_q.pop_front();
        check("wr_addr", caddr_wr, e.addr);
        check("wr_data", cdata_wr, e.data);
        check("wr_cycle", rel, e.rel);
        wr_cnt++;
      end
    end
    if (done) begin
      check("done_cycle", rel, 6145);
      check("done_busy", busy, 1);
      check("write_count", wr_cnt, 2048);
      check("nz_count", nz_count, exp_nz);
      done_seen = 1'b1;
    end
    prev2_crd = prev_crd;
    prev_crd  = crd;
    prev_addr = caddr_rd;
    prev_csel = csel;
  end

  // -------------------------------------------------------- reference model
  // L2 is the two maps interleaved; element m = 2i+k lands at address m and
  // is written in cycle 3m+3 after the start edge.
  task automatic build_expect();
    sb_q.delete();
    exp_nz = 0;
    for (int m = 0; m < 2 * N; m++) begin
      wr_exp_t e;
      e.addr = 12'(m);
      e.data = (m % 2 == 0) ? l1k0[m / 2] : l1k1[m / 2];
      e.rel  = 3 * m + 3;
      if (e.data != 0) exp_nz++;
      sb_q.push_back(e);
    end
  endtask

  task automatic fill_random(input int zero_pct);
    for (int i = 0; i < N; i++) begin
      l1k0[i] = ($urandom_range(99) < zero_pct) ? '0 : DW'($urandom);
      l1k1[i] = ($urandom_range(99) < zero_pct) ? '0 : DW'($urandom);
    end
  endtask

  task automatic sweep_l2(input string name);
    int errs = 0;
    for (int i = 0; i < N; i++) begin
      if (l2[2*i] !== l1k0[i]) errs++;
      if (l2[2*i+1] !== l1k1[i]) errs++;
    end
    check(name, errs, 0);
  endtask

  // Run one pass. busy_start_rel / reset_rel = cycle (relative to the start
  // edge) at which to pulse start again / assert reset; 0 disables.
  task automatic run_pass(input int busy_start_rel, input int reset_rel);
    int rel;
    build_expect();
    wr_cnt    = 0;
    done_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    e0_cyc = cyc;
    start  = 1'b0;
    for (int c = 0; c < 7000 && !done_seen; c++) begin
      rel = cyc - e0_cyc + 1;
      start = (rel == busy_start_rel);
      if (reset_rel != 0 && rel == reset_rel) begin
        reset = 1'b1;
        sb_q.delete();
        #1;
        check("reset_cwr_drop", cwr, 0);
        check("reset_crd_drop", crd, 0);
        check("reset_busy_drop", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", {busy, cwr, crd}, 0);
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!done_seen) check("done_timeout", 0, 1);
    check("sb_drained", sb_q.size(), 0);
    @(posedge clk); #1;
    check("idle_after_fin", {busy, done}, 0);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 2 * N; i++) l2[i] = '0;
    for (int i = 0; i < N; i++) begin
      l1k0[i] = DW'(i << 4);
      l1k1[i] = 20'h80000 | DW'(i);
    end

    // Reset held with start high: everything quiet, no transition.
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {busy, done, crd, cwr, csel, nz_count}, 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", {busy, crd, cwr}, 0);

    // Ramp data.
    run_pass(0, 0);
    check("l2_2046", l2[2046], l1k0[1023]);
    check("l2_2047", l2[2047], l1k1[1023]);
    check("l2_1", l2[1], 20'h80000);
    sweep_l2("ramp_sweep");
    check("nz_held", nz_count, 12'd2047);

    // Sparse data.
    for (int i = 0; i < N; i++) begin
      l1k0[i] = '0;
      l1k1[i] = '0;
    end
    l1k0[5]    = 20'h1;
    l1k1[1023] = 20'hFFFFF;
    run_pass(0, 0);
    check("sparse_l2_10", l2[10], 20'h1);
    check("sparse_l2_2047", l2[2047], 20'hFFFFF);
    check("sparse_nz", nz_count, 2);

    // All nonzero: counter reaches 2048.
    for (int i = 0; i < N; i++) begin
      l1k0[i] = DW'($urandom_range(20'hFFFFF, 1));
      l1k1[i] = DW'($urandom_range(20'hFFFFF, 1));
    end
    run_pass(0, 0);
    check("full_nz", nz_count, 12'd2048);

    // Random data with a start pulse while busy.
    fill_random(30);
    run_pass(100, 0);
    sweep_l2("busy_start_sweep");

    // Reset mid-pass, then a complete pass on new data.
    fill_random(30);
    run_pass(0, 3000);
    check("nz_after_reset", nz_count, 0);
    fill_random(50);
    run_pass(0, 0);
    sweep_l2("post_reset_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_flatten_l2
